// File: rtl/test_port_capture.sv
// Test-port store capture: deduplicates committed stores to TEST_ADDR, tracks the
// BEGIN/END session markers and queues payloads on a valid/ready stream.
// Optional feature macro CAPTURE_TIMESTAMP_EN adds a per-entry 16-bit cycle stamp (out_ts).
module test_port_capture #(
   parameter logic [29:0] TEST_ADDR = 30'h40,
   parameter logic [31:0] BEGIN_SYM = 32'h00000932,
   parameter logic [31:0] END_SYM   = 32'h00000D5D,
   parameter int          DEPTH     = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [29:0]               cpu_addr,
   input  logic [31:0]               cpu_wdata,
   input  logic                      cpu_wen,
   input  logic                      cpu_stall,
   output logic                      out_valid,
   output logic [31:0]               out_data,
   output logic                      out_last,
`ifdef CAPTURE_TIMESTAMP_EN
   output logic [15:0]               out_ts,
`endif
   input  logic                      out_ready,
   output logic                      armed,
   output logic                      done,
   output logic [$clog2(DEPTH):0]    level,
   output logic [7:0]                drop_cnt
);

   localparam int AW = $clog2(DEPTH);
`ifdef CAPTURE_TIMESTAMP_EN
   localparam int W = 49;
`else
   localparam int W = 33;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t        state, next_state;
   logic          hold;
   logic          hit;
   logic          push, push_last;
   logic          pop, full, empty, wr_en, drop;
   logic [AW:0]   wptr, rptr;
   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  wr_entry;
   logic [W-1:0]  rd_entry;

   // A stalled or repeated wen pulse yields one hit; hold re-arms only when wen drops.
   assign hit = cpu_wen & ~cpu_stall & (cpu_addr == TEST_ADDR) & ~hold;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          hold <= 1'b0;
      else if (!cpu_wen) hold <= 1'b0;
      else if (hit)      hold <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      push       = 1'b0;
      push_last  = 1'b0;
      case (state)
         S_IDLE: begin
            if (hit && cpu_wdata == BEGIN_SYM) next_state = S_ARMED;
         end
         S_ARMED: begin
            if (hit) begin
               push = 1'b1;
               if (cpu_wdata == END_SYM) begin
                  push_last  = 1'b1;
                  next_state = S_DONE;
               end
            end
         end
         S_DONE:  next_state = S_DONE;
         default: next_state = S_IDLE;
      endcase
   end

   assign armed = (state == S_ARMED);
   assign done  = (state == S_DONE);

`ifdef CAPTURE_TIMESTAMP_EN
   logic [15:0] ts_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                          ts_cnt <= 16'd0;
      else if (state == S_IDLE && next_state == S_ARMED) ts_cnt <= 16'd0;
      else if (state != S_IDLE)                          ts_cnt <= sat_inc16(ts_cnt);
   end

   assign wr_entry = {ts_cnt, push_last, cpu_wdata};
   assign out_ts   = out_valid ? rd_entry[48:33] : 16'd0;
`else
   assign wr_entry = {push_last, cpu_wdata};
`endif

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop   = out_valid & out_ready;
   // When full, a simultaneous pop frees the slot the push needs.
   assign wr_en = push & (~full | pop);
   assign drop  = push & full & ~pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr     <= '0;
         rptr     <= '0;
         drop_cnt <= 8'd0;
      end else begin
         if (wr_en) wptr <= wptr + 1'b1;
         if (pop)   rptr <= rptr + 1'b1;
         if (drop)  drop_cnt <= sat_inc8(drop_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[AW-1:0]] <= wr_entry;
   end

   assign rd_entry  = mem[rptr[AW-1:0]];
   assign out_valid = ~empty;
   assign out_data  = out_valid ? rd_entry[31:0] : 32'd0;
   assign out_last  = out_valid ? rd_entry[32]   : 1'b0;
   assign level     = wptr - rptr;

endmodule

// File: tb/tb_test_port_capture.sv
// Scoreboard bench for test_port_capture: expected entries queued at stimulus time,
// popped and compared whenever the DUT hands an entry to the checker.
module tb_test_port_capture;

   localparam logic [29:0] TADDR = 30'h40;
   localparam logic [31:0] BSYM  = 32'h00000932;
   localparam logic [31:0] ESYM  = 32'h00000D5D;

   typedef struct packed {
      logic        tsv;
      logic [15:0] ts;
      logic        last;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [29:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic        cpu_wen = 1'b0;
   logic        cpu_stall = 1'b0;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_last;
   logic        out_ready = 1'b0;
   logic        armed, done;
   logic [3:0]  level;
   logic [7:0]  drop_cnt;
`ifdef CAPTURE_TIMESTAMP_EN
   logic [15:0] out_ts;
`endif

   int checks = 0;
   int failures = 0;
   int n_out = 0;
   exp_t sb[$];

   test_port_capture dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_wen   (cpu_wen),
      .cpu_stall (cpu_stall),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
`ifdef CAPTURE_TIMESTAMP_EN
      .out_ts    (out_ts),
`endif
      .out_ready (out_ready),
      .armed     (armed),
      .done      (done),
      .level     (level),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Handshake is stable between negedge and the following posedge, so this sees every pop.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         n_out++;
         if (sb.size() == 0) begin
            check("unexpected_out", {32'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", {32'd0, out_data}, {32'd0, e.data});
            check("out_last", {63'd0, out_last}, {63'd0, e.last});
`ifdef CAPTURE_TIMESTAMP_EN
            if (e.tsv) check("out_ts", {48'd0, out_ts}, {48'd0, e.ts});
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_entry(input logic [31:0] d, input logic last);
      sb.push_back('{tsv: 1'b0, ts: 16'd0, last: last, data: d});
   endtask

   task automatic store(input logic [31:0] d);
      cpu_addr  = TADDR;
      cpu_wdata = d;
      cpu_wen   = 1'b1;
      tick();
      cpu_wen   = 1'b0;
      tick();
   endtask

   task automatic drain();
      int budget = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && budget < 200) begin
         tick();
         budget++;
      end
      tick();
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      sb.delete();
      #1;
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      // reset values, sampled while reset is held
      #2;
      check("rst_valid", {63'd0, out_valid}, 64'd0);
      check("rst_data",  {32'd0, out_data},  64'd0);
      check("rst_last",  {63'd0, out_last},  64'd0);
      check("rst_armed", {63'd0, armed},     64'd0);
      check("rst_done",  {63'd0, done},      64'd0);
      check("rst_level", {60'd0, level},     64'd0);
      check("rst_drop",  {56'd0, drop_cnt},  64'd0);
      tick();
      rst = 1'b1;
      tick();

      // pre-arm filter
      out_ready = 1'b1;
      store(32'd3);
      store(32'd9);
      check("prearm_level", {60'd0, level}, 64'd0);
      check("prearm_out",   64'(n_out),     64'd0);
      store(BSYM);
      check("armed_set", {63'd0, armed}, 64'd1);
      check("armed_level", {60'd0, level}, 64'd0);
      expect_entry(32'd4, 1'b0);
      store(32'd4);
      drain();
      check("prearm_n", 64'(n_out), 64'd1);

      // stall dedup: wen held for four cycles
      n_out = 0;
      expect_entry(32'd7, 1'b0);
      cpu_addr = TADDR; cpu_wdata = 32'd7; cpu_wen = 1'b1;
      cpu_stall = 1'b1; tick();
      cpu_stall = 1'b1; tick();
      cpu_stall = 1'b0; tick();
      cpu_stall = 1'b0; tick();
      cpu_wen = 1'b0;   tick();
      drain();
      check("dedup_n", 64'(n_out), 64'd1);

      // overflow
      out_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         if (i <= 8) expect_entry(32'(i), 1'b0);
         store(32'(i));
      end
      check("ovf_level", {60'd0, level},    64'd8);
      check("ovf_drop",  {56'd0, drop_cnt}, 64'd2);
      check("ovf_valid", {63'd0, out_valid}, 64'd1);

      // full with simultaneous push and pop
      expect_entry(32'd42, 1'b0);
      cpu_addr = TADDR; cpu_wdata = 32'd42; cpu_wen = 1'b1; out_ready = 1'b1;
      tick();
      check("fullpp_level", {60'd0, level},    64'd8);
      check("fullpp_drop",  {56'd0, drop_cnt}, 64'd2);
      cpu_wen = 1'b0;
      tick();
      drain();

      // END marker takes the FSM to DONE; later hits ignored
      expect_entry(ESYM, 1'b1);
      store(ESYM);
      drain();
      check("done_set",  {63'd0, done},  64'd1);
      check("done_arm",  {63'd0, armed}, 64'd0);
      store(32'd55);
      check("done_ignore", {60'd0, level}, 64'd0);

      // begin/end session from a fresh reset
      do_reset();
      n_out = 0;
      out_ready = 1'b1;
      store(BSYM);
      expect_entry(32'd5, 1'b0);
      store(32'd5);
      expect_entry(ESYM, 1'b1);
      store(ESYM);
      drain();
      check("be_n",     64'(n_out),     64'd2);
      check("be_done",  {63'd0, done},  64'd1);
      check("be_level", {60'd0, level}, 64'd0);

      // asynchronous reset mid-session
      do_reset();
      out_ready = 1'b0;
      store(BSYM);
      store(32'd1);
      store(32'd2);
      store(32'd3);
      check("mid_level", {60'd0, level}, 64'd3);
      rst = 1'b0;
      #1;
      check("mid_valid", {63'd0, out_valid}, 64'd0);
      check("mid_lvl0",  {60'd0, level},     64'd0);
      check("mid_armed", {63'd0, armed},     64'd0);
      tick();
      rst = 1'b1;
      tick();
      store(32'd11);
      check("mid_ignore", {60'd0, level}, 64'd0);
      check("mid_idle",   {63'd0, armed}, 64'd0);

`ifdef CAPTURE_TIMESTAMP_EN
      // counter is 0 in the cycle after the arming edge; hits sampled 3 and 6 edges later carry 2 and 5
      out_ready = 1'b0;
      store(BSYM);
      tick();
      sb.push_back('{tsv: 1'b1, ts: 16'd2, last: 1'b0, data: 32'd21});
      cpu_addr = TADDR; cpu_wdata = 32'd21; cpu_wen = 1'b1;
      tick();
      cpu_wen = 1'b0;
      tick();
      tick();
      sb.push_back('{tsv: 1'b1, ts: 16'd5, last: 1'b0, data: 32'd22});
      cpu_wdata = 32'd22; cpu_wen = 1'b1;
      tick();
      cpu_wen = 1'b0;
      tick();
      drain();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
